// File: rtl/enemy_collision_dispatcher.sv
// Double-banked per-enemy collision event store: events are captured during one frame
// and presented back to the owning enemy's pixels during the following frame.
module enemy_collision_dispatcher #(
  parameter int AMOUNT_OF_ENEMIES = 2,
  parameter int DROP_CNT_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      pause,
  input  logic                      newLevel,
  input  logic                      enemyDrawReq,
  input  logic                      headsUpDrawReq,
  input  logic                      headsDownDrawReq,
  input  logic [3:0]                drawingRequestorId,
  input  logic                      wallDrawReq,
  input  logic                      playerShotDrawReq,
  input  logic [2:0]                shotType,
  output logic                      changeDir,
  output logic                      dodgeBullet,
  output logic [2:0]                shotCollision,
  output logic                      killPulse,
  output logic [3:0]                killId,
  output logic [DROP_CNT_WIDTH-1:0] droppedEvents
);

  localparam int N     = AMOUNT_OF_ENEMIES;
  localparam int SUM_W = $clog2(N + 1);

  logic [N-1:0] capChg, capDodge, delChg, delDodge;
  logic [2:0]   capShot [N];
  logic [2:0]   delShot [N];

  logic [N-1:0] capChgNxt, capDodgeNxt, delChgNxt, delDodgeNxt;
  logic [2:0]   capShotNxt [N];
  logic [2:0]   delShotNxt [N];

  logic [SUM_W-1:0] dropSum;
  logic [2:0]       hitCode;
  logic             delActive;
  logic             sel, det, dlv;
  logic             remChg, remDodge, updChg, updDodge;
  logic [2:0]       remShot, updShot;

  function automatic logic [DROP_CNT_WIDTH-1:0] satAdd(
    input logic [DROP_CNT_WIDTH-1:0] acc,
    input logic [SUM_W-1:0]          inc
  );
    logic [DROP_CNT_WIDTH:0] sum;
    sum = {1'b0, acc} + (DROP_CNT_WIDTH + 1)'(inc);
    return sum[DROP_CNT_WIDTH] ? '1 : sum[DROP_CNT_WIDTH-1:0];
  endfunction

  function automatic logic [2:0] maxCode(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    // A body hit with an untyped shot still has to register as a hit
    hitCode   = (shotType == 3'd0) ? 3'd1 : shotType;
    delActive = resetN && enemyDrawReq && !pause;

    changeDir     = 1'b0;
    dodgeBullet   = 1'b0;
    shotCollision = 3'd0;
    dropSum       = '0;
    sel = 1'b0; det = 1'b0; dlv = 1'b0;
    remChg = 1'b0; remDodge = 1'b0; remShot = 3'd0;
    updChg = 1'b0; updDodge = 1'b0; updShot = 3'd0;

    capChgNxt   = capChg;
    capDodgeNxt = capDodge;
    capShotNxt  = capShot;
    delChgNxt   = delChg;
    delDodgeNxt = delDodge;
    delShotNxt  = delShot;

    for (int i = 0; i < N; i++) begin
      sel = (drawingRequestorId == 4'(i));
      det = sel && !pause;
      dlv = sel && delActive;

      if (dlv) begin
        changeDir     = delChg[i];
        shotCollision = delShot[i];
        dodgeBullet   = delDodge[i] && (delShot[i] == 3'd0);
      end

      // Everything for a slot is presented at once, so a delivery empties that slot
      remChg   = delChg[i] && !dlv;
      remDodge = delDodge[i] && !dlv;
      remShot  = dlv ? 3'd0 : delShot[i];

      updChg   = capChg[i] | (det && enemyDrawReq && wallDrawReq);
      updDodge = capDodge[i] | (det && (headsUpDrawReq || headsDownDrawReq)
                                && !enemyDrawReq && playerShotDrawReq);
      updShot  = (det && enemyDrawReq && playerShotDrawReq) ?
                 maxCode(capShot[i], hitCode) : capShot[i];

      if (newLevel) begin
        capChgNxt[i]   = 1'b0;
        capDodgeNxt[i] = 1'b0;
        capShotNxt[i]  = 3'd0;
        delChgNxt[i]   = 1'b0;
        delDodgeNxt[i] = 1'b0;
        delShotNxt[i]  = 3'd0;
      end else if (startOfFrame) begin
        delChgNxt[i]   = updChg;
        delDodgeNxt[i] = updDodge;
        delShotNxt[i]  = updShot;
        capChgNxt[i]   = 1'b0;
        capDodgeNxt[i] = 1'b0;
        capShotNxt[i]  = 3'd0;
        if (remChg || remDodge || (remShot != 3'd0))
          dropSum = dropSum + SUM_W'(1);
      end else begin
        capChgNxt[i]   = updChg;
        capDodgeNxt[i] = updDodge;
        capShotNxt[i]  = updShot;
        delChgNxt[i]   = remChg;
        delDodgeNxt[i] = remDodge;
        delShotNxt[i]  = remShot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      capChg        <= '0;
      capDodge      <= '0;
      capShot       <= '{default: 3'd0};
      delChg        <= '0;
      delDodge      <= '0;
      delShot       <= '{default: 3'd0};
      droppedEvents <= '0;
      killPulse     <= 1'b0;
      killId        <= 4'd0;
    end else begin
      capChg        <= capChgNxt;
      capDodge      <= capDodgeNxt;
      capShot       <= capShotNxt;
      delChg        <= delChgNxt;
      delDodge      <= delDodgeNxt;
      delShot       <= delShotNxt;
      droppedEvents <= satAdd(droppedEvents, dropSum);
      killPulse     <= (shotCollision != 3'd0);
      if (shotCollision != 3'd0)
        killId <= drawingRequestorId;
    end
  end

endmodule

// File: tb/tb_enemy_collision_dispatcher.sv
// Directed and randomized bench for enemy_collision_dispatcher against a frame-level event model.
module tb_enemy_collision_dispatcher;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, pause, newLevel;
  logic       enemyDrawReq, headsUpDrawReq, headsDownDrawReq;
  logic [3:0] drawingRequestorId;
  logic       wallDrawReq, playerShotDrawReq;
  logic [2:0] shotType;
  logic       changeDir, dodgeBullet, killPulse;
  logic [2:0] shotCollision;
  logic [3:0] killId;
  logic [7:0] droppedEvents;

  always #5 clk = ~clk;

  enemy_collision_dispatcher #(.AMOUNT_OF_ENEMIES(N), .DROP_CNT_WIDTH(8)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
    .newLevel(newLevel), .enemyDrawReq(enemyDrawReq), .headsUpDrawReq(headsUpDrawReq),
    .headsDownDrawReq(headsDownDrawReq), .drawingRequestorId(drawingRequestorId),
    .wallDrawReq(wallDrawReq), .playerShotDrawReq(playerShotDrawReq), .shotType(shotType),
    .changeDir(changeDir), .dodgeBullet(dodgeBullet), .shotCollision(shotCollision),
    .killPulse(killPulse), .killId(killId), .droppedEvents(droppedEvents)
  );

  int passCnt = 0, failCnt = 0, totalCnt = 0;

  // Reference: per-slot event records for the frame being gathered and the frame being shown
  int capChgM[N], capDodgeM[N], capShotM[N];
  int delChgM[N], delDodgeM[N], delShotM[N];
  int dropM = 0, kpM = 0, kidM = 0;
  int expChg, expDodge, expShot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic en, input logic wl, input logic hu, input logic hd,
                     input logic ps, input logic [2:0] st, input logic [3:0] id);
    enemyDrawReq = en; wallDrawReq = wl; headsUpDrawReq = hu; headsDownDrawReq = hd;
    playerShotDrawReq = ps; shotType = st; drawingRequestorId = id;
  endtask

  task automatic idle();
    pix(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
  endtask

  task automatic clearBanks();
    for (int i = 0; i < N; i++) begin
      capChgM[i] = 0; capDodgeM[i] = 0; capShotM[i] = 0;
      delChgM[i] = 0; delDodgeM[i] = 0; delShotM[i] = 0;
    end
  endtask

  task automatic sample();
    int k;
    @(negedge clk);
    expChg = 0; expDodge = 0; expShot = 0;
    k = int'(drawingRequestorId);
    if (resetN && enemyDrawReq && !pause && k < N) begin
      expChg   = delChgM[k];
      expShot  = delShotM[k];
      expDodge = (delShotM[k] == 0) ? delDodgeM[k] : 0;
    end
    chk("changeDir", changeDir, expChg);
    chk("dodgeBullet", dodgeBullet, expDodge);
    chk("shotCollision", shotCollision, expShot);
    chk("killPulse", killPulse, kpM);
    chk("killId", killId, kidM);
    chk("droppedEvents", droppedEvents, dropM);
  endtask

  task automatic modelEdge();
    int id, code, cnt;
    id = int'(drawingRequestorId);
    if (!resetN) begin
      clearBanks();
      dropM = 0; kpM = 0; kidM = 0;
      return;
    end
    kpM = (expShot != 0) ? 1 : 0;
    if (kpM != 0) kidM = id;
    if (enemyDrawReq && !pause && id < N) begin
      delChgM[id] = 0; delDodgeM[id] = 0; delShotM[id] = 0;
    end
    if (!pause && id < N) begin
      if (enemyDrawReq && wallDrawReq) capChgM[id] = 1;
      if ((headsUpDrawReq || headsDownDrawReq) && !enemyDrawReq && playerShotDrawReq)
        capDodgeM[id] = 1;
      if (enemyDrawReq && playerShotDrawReq) begin
        code = (shotType == 3'd0) ? 1 : int'(shotType);
        if (code > capShotM[id]) capShotM[id] = code;
      end
    end
    if (newLevel) begin
      clearBanks();
    end else if (startOfFrame) begin
      cnt = 0;
      for (int i = 0; i < N; i++)
        if (delChgM[i] != 0 || delDodgeM[i] != 0 || delShotM[i] != 0) cnt++;
      dropM = (dropM + cnt > 255) ? 255 : dropM + cnt;
      for (int i = 0; i < N; i++) begin
        delChgM[i] = capChgM[i]; delDodgeM[i] = capDodgeM[i]; delShotM[i] = capShotM[i];
        capChgM[i] = 0; capDodgeM[i] = 0; capShotM[i] = 0;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic sofTick();
    idle();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    clearBanks();
    resetN = 1'b0; startOfFrame = 1'b0; pause = 1'b0; newLevel = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    sample();
    chk("rst_drop", droppedEvents, 0);
    chk("rst_kill", killPulse, 0);
    chk("rst_chg", changeDir, 0);
    advance();
    idle();
    tick();
    resetN = 1'b1;

    // change direction after a wall touch
    sofTick();
    repeat (3) begin pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); tick(); end
    idle(); tick();
    sofTick();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); sample(); chk("r34_id0", changeDir, 0); advance();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); sample(); chk("r34_first", changeDir, 1); advance();
    sample(); chk("r34_once", changeDir, 0); advance();

    // largest shot code wins
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 4'd0); tick();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 4'd0); tick();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 4'd0); tick();
    sofTick();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); sample(); chk("r35_shot", shotCollision, 5); advance();
    idle(); sample(); chk("r35_kp", killPulse, 1); chk("r35_kid", killId, 0); advance();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); sample(); chk("r35_once", shotCollision, 0); advance();

    // dodge suppressed by a body hit
    pix(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 4'd1); tick();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd1); tick();
    sofTick();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); sample();
    chk("r36_shot", shotCollision, 1); chk("r36_dodge", dodgeBullet, 0); advance();
    sample(); chk("r36_dodge2", dodgeBullet, 0); chk("r36_kid", killId, 1); advance();

    // undelivered events counted at swap
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); tick();
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); tick();
    sofTick();
    idle(); tick();
    sofTick();
    idle(); sample(); chk("r37_plus2", droppedEvents, 2); advance();

    // pause freezes capture and delivery
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); tick();
    sofTick();
    pause = 1'b1;
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); sample(); chk("r38_paused", changeDir, 0); advance();
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); tick();
    pause = 1'b0;
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); sample(); chk("r38_after", changeDir, 1); advance();
    sofTick();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); sample(); chk("r38_nocap", changeDir, 0); advance();
    idle(); sample(); chk("r38_drop", droppedEvents, 2); advance();

    // new level flushes both banks
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); tick();
    sofTick();
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 4'd1); tick();
    idle(); newLevel = 1'b1; tick(); newLevel = 1'b0;
    repeat (2) begin
      sofTick();
      pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); sample(); chk("r39_id0", changeDir, 0); advance();
      pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); sample();
      chk("r39_id1", changeDir, 0); chk("r39_shot", shotCollision, 0); advance();
    end
    sofTick();
    idle(); sample(); chk("r39_drop", droppedEvents, 2); advance();

    // reset mid-frame discards pending events
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); tick();
    sofTick();
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 4'd1); tick();
    resetN = 1'b0;
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); sample(); chk("rstmid_chg", changeDir, 0); advance();
    sample(); chk("rstmid_drop", droppedEvents, 0); chk("rstmid_kp", killPulse, 0); advance();
    resetN = 1'b1;
    sofTick();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); sample(); chk("rstmid_id0", changeDir, 0); advance();
    pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); sample(); chk("rstmid_id1", shotCollision, 0); advance();
    sofTick();
    idle(); sample(); chk("rstmid_nodrop", droppedEvents, 0); advance();

    // randomized traffic, including out-of-range slot ids
    for (int n = 0; n < 3000; n++) begin
      resetN       = ($urandom_range(0, 199) != 0);
      startOfFrame = ($urandom_range(0, 9) == 0);
      pause        = ($urandom_range(0, 9) == 0);
      newLevel     = ($urandom_range(0, 99) == 0);
      pix(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
          3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
      tick();
    end
    resetN = 1'b1; startOfFrame = 1'b0; pause = 1'b0; newLevel = 1'b0;

    // drop counter saturation
    for (int n = 0; n < 130; n++) begin
      pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); tick();
      pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1); tick();
      sofTick();
      sofTick();
    end
    idle(); sample(); chk("r37_sat", droppedEvents, 255); advance();
    pix(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0); tick();
    sofTick();
    sofTick();
    idle(); sample(); chk("r37_hold", droppedEvents, 255); advance();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
